// File: rtl/cmd_stream_decoder_pkg.sv
// Shared decoder definitions: assembler state encoding, opcode length-field
// extraction (also used by the executor), and parameter legality checks.
// No ports; imported by the decoder, its interface and downstream engines.
package cmd_stream_decoder_pkg;

    // Assembler states.
    localparam logic [0:0] ST_IDLE = 1'b0;  // next accepted word is an opcode
    localparam logic [0:0] ST_ARGS = 1'b1;  // collecting argument words

    // Widest bus word the length helper can take.
    localparam int unsigned OPC_MAX_W = 64;

    // Argument count carried in the top len_bits bits of a data_w-wide opcode.
    function automatic logic [31:0] opcode_len(input logic [OPC_MAX_W-1:0] opcode,
                                               input int unsigned data_w,
                                               input int unsigned len_bits);
        logic [OPC_MAX_W-1:0] shifted;
        shifted = opcode >> (data_w - len_bits);
        return shifted[31:0] & ((32'd1 << len_bits) - 32'd1);
    endfunction

    // Instruction must be a power-of-2 (>=2) number of bus words, the length
    // field must fit in one word, and the queue depth must be a power of 2 (>=2).
    function automatic bit cfg_legal(input int unsigned data_w,
                                     input int unsigned instr_w,
                                     input int unsigned fifo_depth);
        int unsigned nw;
        if (data_w == 0 || data_w > OPC_MAX_W || (instr_w % data_w) != 0) return 1'b0;
        nw = instr_w / data_w;
        if (nw < 2 || (nw & (nw - 1)) != 0) return 1'b0;
        if ($clog2(nw) > data_w) return 1'b0;
        return (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/cmd_stream_decoder_if.sv
// Host write bus plus executor valid/ready handshake of the command decoder.
// Host side: i_we/i_en/i_data/i_flush in, o_ack/o_busy/o_count out.
// Executor side: o_instruction/o_len/o_instruction_valid out, i_instruction_ready in.
interface cmd_stream_decoder_if #(
    parameter int DATA_W     = 8,
    parameter int INSTR_W    = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int LEN_BITS = $clog2(INSTR_W / DATA_W);
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

    logic                i_we;
    logic                i_en;
    logic [DATA_W-1:0]   i_data;
    logic                o_ack;
    logic                i_flush;
    logic [INSTR_W-1:0]  o_instruction;
    logic [LEN_BITS-1:0] o_len;
    logic                o_instruction_valid;
    logic                i_instruction_ready;
    logic                o_busy;
    logic [CNT_W-1:0]    o_count;

    // Decoder side.
    modport slave (
        input  i_we, i_en, i_data, i_flush, i_instruction_ready,
        output o_ack, o_instruction, o_len, o_instruction_valid, o_busy, o_count
    );

    // Host / executor side.
    modport master (
        output i_we, i_en, i_data, i_flush, i_instruction_ready,
        input  o_ack, o_instruction, o_len, o_instruction_valid, o_busy, o_count
    );
endinterface

// File: rtl/cmd_stream_decoder_instr_fifo.sv
// First-word-fall-through instruction queue with flush and occupancy count.
// Latency: a push at edge N is visible at o_head from cycle N+1 when empty.
// Backpressure: o_full blocks pushes; pushes while full and pops while empty are ignored.
// Ports: i_clk, i_reset (async, active-high), i_flush, i_push/i_push_data,
//        i_pop, o_head, o_full, o_empty, o_count.
module instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (count == CW'(DEPTH));
    assign o_empty = (count == '0);
    assign o_count = count;
    assign o_head  = mem[rd_ptr];

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= i_push_data;
                wr_ptr      <= wr_ptr + 1'b1;  // DEPTH is a power of 2: natural wrap
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/cmd_stream_decoder.sv
// Assembles variable-length instructions from a narrow write bus and queues them.
// Latency: last word accepted at edge N -> instruction valid (empty queue) and o_ack in cycle N+1.
// Backpressure: full queue stalls the host (no o_ack); host holds its word until acked.
// Ports: i_clk, i_reset (async, active-high), bus (cmd_stream_decoder_if.slave).
module cmd_stream_decoder
    import cmd_stream_decoder_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int INSTR_W    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    cmd_stream_decoder_if.slave  bus
);
    localparam int NUM_WORDS = INSTR_W / DATA_W;
    localparam int LEN_BITS  = $clog2(NUM_WORDS);
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

    if (!cfg_legal(DATA_W, INSTR_W, FIFO_DEPTH)) begin : g_bad_cfg
        $error("cmd_stream_decoder: illegal DATA_W/INSTR_W/FIFO_DEPTH combination");
    end

    logic [0:0]          state;
    logic [LEN_BITS-1:0] arg_cnt;   // argument words still to come
    logic [LEN_BITS-1:0] idx;       // slot of the next argument word
    logic [INSTR_W-1:0]  asm_q;
    logic [INSTR_W-1:0]  asm_next;
    logic                ack_q;
    logic [LEN_BITS-1:0] op_len;
    logic                accept;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [INSTR_W-1:0]  head;

    assign op_len = LEN_BITS'(opcode_len(OPC_MAX_W'(bus.i_data), DATA_W, LEN_BITS));

    // Fullness is sampled before any same-cycle pop, so a slot freed by a pop
    // only becomes usable on the following edge.
    assign accept = bus.i_we && bus.i_en && !fifo_full && !bus.i_flush;
    assign pop    = !fifo_empty && bus.i_instruction_ready && !bus.i_flush;

    // Next assembly value; pushed straight into the queue when the word
    // completes the instruction, so the register never lags the FIFO.
    always_comb begin
        asm_next = asm_q;
        push     = 1'b0;
        if (state == ST_IDLE) begin
            asm_next               = '0;
            asm_next[DATA_W-1:0]   = bus.i_data;
            push                   = accept && (op_len == '0);
        end else begin
            asm_next[idx*DATA_W +: DATA_W] = bus.i_data;
            push                           = accept && (arg_cnt == LEN_BITS'(1));
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            arg_cnt <= '0;
            idx     <= '0;
            asm_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= accept;
            if (bus.i_flush) begin
                state   <= ST_IDLE;
                arg_cnt <= '0;
                idx     <= '0;
            end else if (accept) begin
                asm_q <= asm_next;
                if (state == ST_IDLE) begin
                    if (op_len != '0) begin
                        arg_cnt <= op_len;
                        idx     <= LEN_BITS'(1);
                        state   <= ST_ARGS;
                    end
                end else begin
                    arg_cnt <= arg_cnt - 1'b1;
                    idx     <= idx + 1'b1;
                    if (arg_cnt == LEN_BITS'(1)) state <= ST_IDLE;
                end
            end
        end
    end

    instr_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_flush     (bus.i_flush),
        .i_push      (push),
        .i_push_data (asm_next),
        .i_pop       (pop),
        .o_head      (head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_count     (fifo_count)
    );

    assign bus.o_ack               = ack_q;
    assign bus.o_instruction       = head;
    assign bus.o_len               = LEN_BITS'(opcode_len(OPC_MAX_W'(head[DATA_W-1:0]), DATA_W, LEN_BITS));
    assign bus.o_instruction_valid = !fifo_empty;
    assign bus.o_count             = fifo_count;
    assign bus.o_busy              = (state != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_cmd_stream_decoder.sv
// Bench for cmd_stream_decoder: directed scenarios plus a randomized run
// against a queue-based model of instruction assembly and queueing.
// A second instance covers the 16-bit bus / 64-bit instruction configuration.
module tb_cmd_stream_decoder;

    localparam int DEPTH = 4;

    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    always #5 i_clk = ~i_clk;

    cmd_stream_decoder_if #(.DATA_W(8),  .INSTR_W(32), .FIFO_DEPTH(DEPTH)) bus ();
    cmd_stream_decoder_if #(.DATA_W(16), .INSTR_W(64), .FIFO_DEPTH(DEPTH)) bus16 ();

    cmd_stream_decoder #(.DATA_W(8), .INSTR_W(32), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk (i_clk), .i_reset (i_reset), .bus (bus.slave)
    );
    cmd_stream_decoder #(.DATA_W(16), .INSTR_W(64), .FIFO_DEPTH(DEPTH)) dut16 (
        .i_clk (i_clk), .i_reset (i_reset), .bus (bus16.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queued instructions and words of the partial one.
    logic [31:0] exp_q[$];
    logic [7:0]  part[$];
    bit          exp_ack = 1'b0;

    task automatic model_clear();
        exp_q.delete(); part.delete(); exp_ack = 1'b0;
    endtask

    // Applies the inputs currently driven on bus to the model for one edge.
    task automatic model_edge();
        bit acc, pop;
        int len;
        logic [31:0] inst;
        acc = bus.i_we && bus.i_en && (exp_q.size() < DEPTH) && !bus.i_flush;
        pop = !bus.i_flush && (exp_q.size() > 0) && bus.i_instruction_ready;
        if (bus.i_flush) begin
            exp_q.delete(); part.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                part.push_back(bus.i_data);
                len = int'(part[0][7:6]);
                if (part.size() == len + 1) begin
                    inst = '0;
                    foreach (part[i]) inst[i*8 +: 8] = part[i];
                    exp_q.push_back(inst);
                    part.delete();
                end
            end
        end
        exp_ack = acc;
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        model_edge();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic idle();
        bus.i_we = 1'b0; bus.i_en = 1'b0; bus.i_data = '0;
        bus.i_flush = 1'b0; bus.i_instruction_ready = 1'b0;
    endtask

    task automatic offer(input logic [7:0] d);
        bus.i_we = 1'b1; bus.i_en = 1'b1; bus.i_data = d;
    endtask

    task automatic test_reset();
        idle();
        bus16.i_we = 1'b0; bus16.i_en = 1'b0; bus16.i_data = '0;
        bus16.i_flush = 1'b0; bus16.i_instruction_ready = 1'b0;
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++; if ({bus.o_ack, bus.o_instruction_valid, bus.o_busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got ack/valid/busy=%b required 000", {bus.o_ack, bus.o_instruction_valid, bus.o_busy}); end
        checks++; if (bus.o_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", bus.o_count); end
        checks++; if ({bus.o_instruction, bus.o_len} !== 34'd0) begin errors++; $display("FAIL reset_instr: got %h len %0d required 0", bus.o_instruction, bus.o_len); end
        checks++; if ({bus16.o_instruction, bus16.o_instruction_valid, bus16.o_busy} !== 66'd0) begin errors++; $display("FAIL reset_wide: got %h required 0", bus16.o_instruction); end
        i_reset = 1'b0;
        model_clear();
    endtask

    task automatic test_single_word();
        offer(8'h05);
        tick();
        idle();
        checks++; if (bus.o_ack !== 1'b1) begin errors++; $display("FAIL single_ack: got %b required 1", bus.o_ack); end
        checks++; if (bus.o_instruction !== 32'h0000_0005) begin errors++; $display("FAIL single_instr: got %h required 00000005", bus.o_instruction); end
        checks++; if ({bus.o_instruction_valid, bus.o_len, bus.o_count} !== {1'b1, 2'd0, 3'd1}) begin errors++; $display("FAIL single_valid_len_count: got %b/%0d/%0d required 1/0/1", bus.o_instruction_valid, bus.o_len, bus.o_count); end
        bus.i_instruction_ready = 1'b1;
        tick();
        idle();
        checks++; if ({bus.o_instruction_valid, bus.o_busy, bus.o_ack, bus.o_count} !== 6'd0) begin errors++; $display("FAIL single_pop: got valid/busy/ack=%b%b%b count %0d required all 0", bus.o_instruction_valid, bus.o_busy, bus.o_ack, bus.o_count); end
    endtask

    task automatic test_multi_word();
        logic [7:0] seq [4] = '{8'hC1, 8'hAA, 8'hBB, 8'hCC};
        int acks = 0;
        for (int i = 0; i < 4; i++) begin
            offer(seq[i]);
            tick();
            if (bus.o_ack === 1'b1) acks++;
            if (i < 3) begin
                checks++; if (bus.o_instruction_valid !== 1'b0) begin errors++; $display("FAIL multi_early_valid word %0d: got %b required 0", i, bus.o_instruction_valid); end
            end
        end
        idle();
        checks++; if (bus.o_instruction_valid !== 1'b1) begin errors++; $display("FAIL multi_valid: got %b required 1", bus.o_instruction_valid); end
        checks++; if (bus.o_instruction !== 32'hCCBB_AAC1) begin errors++; $display("FAIL multi_instr: got %h required CCBBAAC1", bus.o_instruction); end
        checks++; if ({bus.o_len, bus.o_count} !== {2'd3, 3'd1}) begin errors++; $display("FAIL multi_len_count: got %0d/%0d required 3/1", bus.o_len, bus.o_count); end
        tick();
        if (bus.o_ack === 1'b1) acks++;
        checks++; if (acks !== 4) begin errors++; $display("FAIL multi_ack_pulses: got %0d required 4", acks); end
        bus.i_instruction_ready = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_full_stall();
        for (int i = 0; i < 4; i++) begin
            offer(8'(i + 1));
            tick();
            checks++; if (bus.o_ack !== 1'b1) begin errors++; $display("FAIL fill_ack %0d: got %b required 1", i, bus.o_ack); end
        end
        checks++; if (bus.o_count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d required 4", bus.o_count); end
        offer(8'h05);
        tick();
        checks++; if ({bus.o_ack, bus.o_count} !== {1'b0, 3'd4}) begin errors++; $display("FAIL stall: got ack %b count %0d required 0/4", bus.o_ack, bus.o_count); end
        bus.i_instruction_ready = 1'b1;
        tick();
        bus.i_instruction_ready = 1'b0;
        checks++; if ({bus.o_ack, bus.o_count} !== {1'b0, 3'd3}) begin errors++; $display("FAIL stall_pop: got ack %b count %0d required 0/3", bus.o_ack, bus.o_count); end
        checks++; if (bus.o_instruction !== 32'h0000_0002) begin errors++; $display("FAIL stall_head: got %h required 00000002", bus.o_instruction); end
        tick();
        idle();
        checks++; if ({bus.o_ack, bus.o_count} !== {1'b1, 3'd4}) begin errors++; $display("FAIL stall_release: got ack %b count %0d required 1/4", bus.o_ack, bus.o_count); end
        bus.i_instruction_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.o_instruction !== 32'(i + 2)) begin errors++; $display("FAIL drain_head %0d: got %h required %h", i, bus.o_instruction, 32'(i + 2)); end
            tick();
        end
        idle();
        checks++; if ({bus.o_count, bus.o_busy} !== 4'd0) begin errors++; $display("FAIL drain_end: got count %0d busy %b required 0/0", bus.o_count, bus.o_busy); end
    endtask

    task automatic test_flush();
        offer(8'h07); tick();
        offer(8'h81); tick();
        offer(8'h11); tick();
        checks++; if ({bus.o_busy, bus.o_count} !== {1'b1, 3'd1}) begin errors++; $display("FAIL preflush: got busy %b count %0d required 1/1", bus.o_busy, bus.o_count); end
        offer(8'h33);
        bus.i_flush = 1'b1; bus.i_instruction_ready = 1'b1;
        tick();
        idle();
        checks++; if (bus.o_ack !== 1'b0) begin errors++; $display("FAIL flush_ack: got %b required 0", bus.o_ack); end
        checks++; if ({bus.o_count, bus.o_busy, bus.o_instruction_valid} !== 5'd0) begin errors++; $display("FAIL flush_clear: got count %0d busy %b valid %b required 0", bus.o_count, bus.o_busy, bus.o_instruction_valid); end
        offer(8'h02); tick(); idle();
        checks++; if ({bus.o_ack, bus.o_instruction_valid, bus.o_len} !== {1'b1, 1'b1, 2'd0}) begin errors++; $display("FAIL postflush_flags: got ack %b valid %b len %0d required 1/1/0", bus.o_ack, bus.o_instruction_valid, bus.o_len); end
        checks++; if (bus.o_instruction !== 32'h0000_0002) begin errors++; $display("FAIL postflush_instr: got %h required 00000002", bus.o_instruction); end
        bus.i_instruction_ready = 1'b1; tick(); idle();
    endtask

    task automatic test_async_reset();
        // Mid-ARGS.
        offer(8'h81); tick();
        offer(8'h11); tick();
        offer(8'h22);
        #2 i_reset = 1'b1;
        #1;
        checks++; if ({bus.o_ack, bus.o_instruction_valid, bus.o_busy, bus.o_count, bus.o_len} !== 8'd0) begin errors++; $display("FAIL areset_args: got ack %b valid %b busy %b count %0d len %0d required 0", bus.o_ack, bus.o_instruction_valid, bus.o_busy, bus.o_count, bus.o_len); end
        @(posedge i_clk); @(negedge i_clk);
        idle(); i_reset = 1'b0; model_clear();
        tick();
        checks++; if ({bus.o_ack, bus.o_busy} !== 2'b00) begin errors++; $display("FAIL areset_args_after: got ack %b busy %b required 0/0", bus.o_ack, bus.o_busy); end
        offer(8'h02); tick(); idle();
        checks++; if ({bus.o_instruction, bus.o_count} !== {32'h0000_0002, 3'd1}) begin errors++; $display("FAIL areset_fresh: got %h count %0d required 00000002/1", bus.o_instruction, bus.o_count); end
        // Mid-stall.
        for (int i = 0; i < 4; i++) begin offer(8'h10 + 8'(i)); tick(); end
        offer(8'h3F); tick();
        #2 i_reset = 1'b1;
        #1;
        checks++; if ({bus.o_ack, bus.o_instruction_valid, bus.o_busy, bus.o_count} !== 6'd0) begin errors++; $display("FAIL areset_stall: got ack %b valid %b busy %b count %0d required 0", bus.o_ack, bus.o_instruction_valid, bus.o_busy, bus.o_count); end
        checks++; if (bus.o_instruction !== 32'd0) begin errors++; $display("FAIL areset_stall_instr: got %h required 0", bus.o_instruction); end
        @(posedge i_clk); @(negedge i_clk);
        idle(); i_reset = 1'b0; model_clear();
        tick();
        checks++; if (bus.o_ack !== 1'b0) begin errors++; $display("FAIL areset_stall_after: got ack %b required 0", bus.o_ack); end
    endtask

    task automatic test_back_to_back();
        bus.i_instruction_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer({2'b00, 6'(i + 9)});
            tick();
            checks++; if ({bus.o_ack, bus.o_count} !== {1'b1, 3'd1}) begin errors++; $display("FAIL b2b_flow %0d: got ack %b count %0d required 1/1", i, bus.o_ack, bus.o_count); end
            checks++; if (bus.o_instruction !== 32'(i + 9)) begin errors++; $display("FAIL b2b_instr %0d: got %h required %h", i, bus.o_instruction, 32'(i + 9)); end
        end
        idle();
        bus.i_instruction_ready = 1'b1; tick(); idle();
    endtask

    task automatic test_random();
        logic [7:0] w;
        w = 8'($urandom);
        for (int c = 0; c < 400; c++) begin
            bus.i_we = ($urandom_range(0, 3) != 0);
            bus.i_en = ($urandom_range(0, 7) != 0);
            bus.i_data = w;
            bus.i_instruction_ready = 1'($urandom_range(0, 1));
            bus.i_flush = ($urandom_range(0, 40) == 0);
            tick();
            if (exp_ack) w = 8'($urandom);
            checks++; if (bus.o_ack !== exp_ack) begin errors++; $display("FAIL rnd_ack cycle %0d: got %b required %b", c, bus.o_ack, exp_ack); end
            checks++; if (bus.o_count !== 3'(exp_q.size())) begin errors++; $display("FAIL rnd_count cycle %0d: got %0d required %0d", c, bus.o_count, exp_q.size()); end
            checks++; if (bus.o_busy !== ((part.size() != 0) || (exp_q.size() != 0))) begin errors++; $display("FAIL rnd_busy cycle %0d: got %b", c, bus.o_busy); end
            checks++; if (bus.o_instruction_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_valid cycle %0d: got %b", c, bus.o_instruction_valid); end
            if (exp_q.size() != 0) begin
                checks++; if ({bus.o_instruction, bus.o_len} !== {exp_q[0], exp_q[0][7:6]}) begin errors++; $display("FAIL rnd_head cycle %0d: got %h len %0d required %h", c, bus.o_instruction, bus.o_len, exp_q[0]); end
            end
        end
        idle();
    endtask

    task automatic test_wide();
        logic [15:0] w [4];
        logic [15:0] a4;
        w[0] = 16'hC000; w[1] = 16'($urandom); w[2] = 16'($urandom); w[3] = 16'($urandom);
        a4 = 16'($urandom);
        idle();
        for (int i = 0; i < 4; i++) begin
            bus16.i_we = 1'b1; bus16.i_en = 1'b1; bus16.i_data = w[i];
            tick();
            checks++; if (bus16.o_ack !== 1'b1) begin errors++; $display("FAIL wide_ack %0d: got %b required 1", i, bus16.o_ack); end
        end
        bus16.i_data = 16'h4005; tick();
        bus16.i_data = a4; tick();
        bus16.i_we = 1'b0; bus16.i_en = 1'b0;
        checks++; if (bus16.o_instruction !== {w[3], w[2], w[1], w[0]}) begin errors++; $display("FAIL wide_instr: got %h required %h", bus16.o_instruction, {w[3], w[2], w[1], w[0]}); end
        checks++; if ({bus16.o_len, bus16.o_count} !== {2'd3, 3'd2}) begin errors++; $display("FAIL wide_len_count: got %0d/%0d required 3/2", bus16.o_len, bus16.o_count); end
        bus16.i_instruction_ready = 1'b1; tick(); bus16.i_instruction_ready = 1'b0;
        checks++; if ({bus16.o_instruction, bus16.o_len} !== {32'h0, a4, 16'h4005, 2'd1}) begin errors++; $display("FAIL wide_short: got %h len %0d required %h len 1", bus16.o_instruction, bus16.o_len, {32'h0, a4, 16'h4005}); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_multi_word();
        test_full_stall();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
